iob_ila_dump: RTL and testbench
===============================

IOB_ILA_DUMP -- requirements
Module: iob_ila_dump

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 4, IOb-Native address width of the ILA register bus.
- DATA_W, 32, bus and stream data width.
- SIGNAL_W, 32, ILA sampled signal width.
- BUFFER_W, 10, ILA sample index width; BUFFER_W <= 16.
- N_SAMPLES_ADDR, 0, N_SAMPLES register address.
- INDEX_ADDR, 1, INDEX register address.
- SIGNAL_SELECT_ADDR, 2, SIGNAL_SELECT register address.
- SAMPLE_DATA_ADDR, 3, SAMPLE_DATA register address.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- cke_i, in, 1, clock enable; when low, all state holds.
- arst_i, in, 1, reset; synchronous, active-high.
- start_i, in, 1, start dump pulse.
- abort_i, in, 1, abort dump.
- busy_o, out, 1, dump in progress.
- done_o, out, 1, one-cycle completion pulse.
- count_o, out, 16, sample count latched from N_SAMPLES.
- iob_avalid_o, out, 1, request valid.
- iob_addr_o, out, ADDR_W, request address.
- iob_wdata_o, out, DATA_W, write data.
- iob_wstrb_o, out, DATA_W/8, write strobe; 0 = read.
- iob_ready_i, in, 1, request accepted.
- iob_rvalid_i, in, 1, read data valid.
- iob_rdata_i, in, DATA_W, read data.
- m_valid_o, out, 1, stream word valid.
- m_data_o, out, DATA_W, stream word.
- m_last_o, out, 1, final word of dump.
- m_ready_i, in, 1, stream ready.

Function
REQ-003 WORDS SHALL equal ceil(SIGNAL_W/DATA_W), the number of words per sample.
REQ-004 The FSM SHALL have these states and transitions:
- IDLE -> RD_N -> WAIT_N.
- WAIT_N -> WR_IDX -> WR_SEL -> RD_DATA -> WAIT_DATA -> OUT.
- OUT -> WR_SEL (next word), WR_IDX (next sample), or DONE.
- DONE -> IDLE.
REQ-005 In IDLE, a start_i high with cke_i high SHALL enter RD_N on the next cycle; start_i SHALL be ignored in every other state.
REQ-006 A bus request SHALL hold iob_avalid_o, iob_addr_o, iob_wdata_o and iob_wstrb_o stable until the cycle iob_ready_i is high, and SHALL drop iob_avalid_o on the following cycle.
REQ-007 Writes SHALL use all-ones iob_wstrb_o; reads SHALL use iob_wstrb_o = 0.
REQ-008 A read SHALL wait in its WAIT state for iob_rvalid_i and capture iob_rdata_i in the cycle rvalid is high; rvalid may arrive the cycle after ready or later.
REQ-009 RD_N SHALL read N_SAMPLES_ADDR; WAIT_N SHALL latch rdata[15:0] into count_o.
REQ-010 If count_o is 0, WAIT_N SHALL go to DONE, with no stream output.
REQ-011 WR_IDX SHALL write the sample index i, zero-extended to DATA_W, to INDEX_ADDR; i SHALL start at 0 and run to count_o-1.
REQ-012 WR_SEL SHALL write word index w to SIGNAL_SELECT_ADDR; w SHALL start at 0 for each sample and run to WORDS-1.
REQ-013 RD_DATA SHALL read SAMPLE_DATA_ADDR; WAIT_DATA SHALL capture the result into m_data_o.
REQ-014 OUT SHALL assert m_valid_o with m_data_o stable until m_valid_o and m_ready_i are both high (backpressure stalls indefinitely).
REQ-015 m_last_o SHALL be high in OUT only when i = count_o-1 and w = WORDS-1.
REQ-016 Transitions out of OUT:
- Not last word of the sample: w increments, go to WR_SEL.
- Last word, not last sample: i increments, w clears, go to WR_IDX.
- Last word of last sample: go to DONE.
REQ-017 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-018 busy_o SHALL be high in every state except IDLE.
REQ-019 Abort handling:
- abort_i high in WR_IDX, WR_SEL, RD_N or RD_DATA before the handshake completes SHALL not take effect until the outstanding request completes.
- A pending read SHALL also wait for its rvalid before abort takes effect.
- After that, the block SHALL go to DONE with no further stream words.
- abort_i in OUT SHALL drop m_valid_o and go to DONE.
- abort_i in IDLE SHALL have no effect.
REQ-020 Counters i and w SHALL be 16 bits wide; count_o = 65535 SHALL dump 65535 samples with no wrap before completion.
REQ-021 With cke_i low, all registers and outputs SHALL hold their values.

Reset
REQ-022 arst_i high at a rising clk_i edge, regardless of cke_i or state, SHALL force on the next cycle:
- FSM to IDLE;
- busy_o, done_o, iob_avalid_o, m_valid_o and m_last_o to 0;
- iob_addr_o, iob_wdata_o, iob_wstrb_o, m_data_o, count_o, i and w to 0.
REQ-023 Reset mid-request SHALL abandon the transaction; a late iob_rvalid_i arriving in IDLE SHALL be ignored.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Basic dump: N_SAMPLES=3, SIGNAL_W=32, bus ready immediate, rvalid +1 cycle, m_ready_i=1 -> 3 words equal to SAMPLE_DATA for index 0,1,2; m_last_o on the 3rd word; done_o 1 cycle; INDEX writes 0,1,2.
- Multi-word samples: SIGNAL_W=64, N_SAMPLES=2 -> 4 words; SIGNAL_SELECT writes 0,1,0,1; m_last_o on the 4th word only.
- Empty buffer: N_SAMPLES=0 -> no m_valid_o; done_o 1 cycle after rvalid; count_o=0.
- Stalls: ready delayed 3 cycles, rvalid delayed 2, m_ready_i low 5 cycles -> request fields stable throughout each stall; data order and values unchanged.
- Abort: abort_i pulsed during WAIT_DATA of sample 1 of 4 -> rvalid consumed; no further m_valid_o; done_o asserted; busy_o low afterwards.
- Reset and start: arst_i asserted during OUT -> next cycle all outputs 0; a late rvalid is ignored; start_i during busy does not restart; a start after reset performs a full dump.

Source files
------------

// File: rtl/iob_ila_dump.sv
// Reads an ILA capture buffer over an IOb-Native register bus and streams every
// sample word out, one bus transaction at a time.
module iob_ila_dump #(
    parameter int ADDR_W             = 4,
    parameter int DATA_W             = 32,
    parameter int SIGNAL_W           = 32,
    parameter int BUFFER_W           = 10,
    parameter int N_SAMPLES_ADDR     = 0,
    parameter int INDEX_ADDR         = 1,
    parameter int SIGNAL_SELECT_ADDR = 2,
    parameter int SAMPLE_DATA_ADDR   = 3
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           count_o,
    output logic                  iob_avalid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i,
    output logic                  m_valid_o,
    output logic [DATA_W-1:0]     m_data_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i
);
    localparam int          WORDS     = (SIGNAL_W + DATA_W - 1) / DATA_W;
    localparam logic [15:0] LAST_WORD = 16'(WORDS - 1);
    localparam int          STRB_W    = DATA_W / 8;

    if (BUFFER_W > 16) begin : g_buffer_w_check
        $error("iob_ila_dump: BUFFER_W must not exceed 16");
    end

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_N,
        ST_WAIT_N,
        ST_WR_IDX,
        ST_WR_SEL,
        ST_RD_DATA,
        ST_WAIT_DATA,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic                avalid_reg, avalid_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
    logic                m_valid_reg, m_valid_next;
    logic [DATA_W-1:0]   m_data_reg, m_data_next;
    logic                m_last_reg, m_last_next;
    logic [15:0]         count_reg, count_next;
    logic [15:0]         i_reg, i_next;
    logic [15:0]         w_reg, w_next;
    logic                abort_pend_reg, abort_pend_next;

    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                req_write;
    logic                last_word;
    logic                last_sample;

    assign last_word   = (w_reg == LAST_WORD);
    // 17-bit compare so count = 65535 never wraps the sample index
    assign last_sample = ((17'(i_reg) + 17'd1) == 17'(count_reg));

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_reg      <= ST_IDLE;
            avalid_reg     <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_last_reg     <= 1'b0;
            count_reg      <= '0;
            i_reg          <= '0;
            w_reg          <= '0;
            abort_pend_reg <= 1'b0;
        end else if (cke_i) begin
            state_reg      <= state_next;
            avalid_reg     <= avalid_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
            m_valid_reg    <= m_valid_next;
            m_data_reg     <= m_data_next;
            m_last_reg     <= m_last_next;
            count_reg      <= count_next;
            i_reg          <= i_next;
            w_reg          <= w_next;
            abort_pend_reg <= abort_pend_next;
        end
    end

    // Fields of the request each bus state issues
    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_write = 1'b0;
        case (state_reg)
            ST_RD_N:    req_addr = ADDR_W'(N_SAMPLES_ADDR);
            ST_WR_IDX: begin
                req_addr  = ADDR_W'(INDEX_ADDR);
                req_wdata = DATA_W'(i_reg);
                req_write = 1'b1;
            end
            ST_WR_SEL: begin
                req_addr  = ADDR_W'(SIGNAL_SELECT_ADDR);
                req_wdata = DATA_W'(w_reg);
                req_write = 1'b1;
            end
            ST_RD_DATA: req_addr = ADDR_W'(SAMPLE_DATA_ADDR);
            default:    ;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        avalid_next     = avalid_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        m_valid_next    = m_valid_reg;
        m_data_next     = m_data_reg;
        m_last_next     = m_last_reg;
        count_next      = count_reg;
        i_next          = i_reg;
        w_next          = w_reg;
        abort_pend_next = abort_pend_reg | abort_i;

        case (state_reg)
            ST_IDLE: begin
                abort_pend_next = 1'b0;
                if (start_i) begin
                    state_next = ST_RD_N;
                end
            end
            // The entry cycle of a bus state loads the request; avalid then
            // holds until ready, and an abort only acts once nothing is in flight.
            ST_RD_N, ST_WR_IDX, ST_WR_SEL, ST_RD_DATA: begin
                if (!avalid_reg) begin
                    if (abort_pend_next) begin
                        state_next = ST_DONE;
                    end else begin
                        avalid_next = 1'b1;
                        addr_next   = req_addr;
                        wdata_next  = req_wdata;
                        wstrb_next  = req_write ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
                    end
                end else if (iob_ready_i) begin
                    avalid_next = 1'b0;
                    if (state_reg == ST_RD_N) begin
                        state_next = ST_WAIT_N;
                    end else if (state_reg == ST_RD_DATA) begin
                        state_next = ST_WAIT_DATA;
                    end else if (abort_pend_next) begin
                        state_next = ST_DONE;
                    end else if (state_reg == ST_WR_IDX) begin
                        state_next = ST_WR_SEL;
                    end else begin
                        state_next = ST_RD_DATA;
                    end
                end
            end
            ST_WAIT_N: begin
                if (iob_rvalid_i) begin
                    count_next = iob_rdata_i[15:0];
                    i_next     = '0;
                    w_next     = '0;
                    if (abort_pend_next || (iob_rdata_i[15:0] == 16'd0)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WR_IDX;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (iob_rvalid_i) begin
                    if (abort_pend_next) begin
                        state_next = ST_DONE;
                    end else begin
                        m_data_next  = iob_rdata_i;
                        m_valid_next = 1'b1;
                        m_last_next  = last_sample && last_word;
                        state_next   = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (abort_i) begin
                    m_valid_next = 1'b0;
                    m_last_next  = 1'b0;
                    state_next   = ST_DONE;
                end else if (m_ready_i) begin
                    m_valid_next = 1'b0;
                    m_last_next  = 1'b0;
                    if (!last_word) begin
                        w_next     = w_reg + 16'd1;
                        state_next = ST_WR_SEL;
                    end else if (!last_sample) begin
                        i_next     = i_reg + 16'd1;
                        w_next     = '0;
                        state_next = ST_WR_IDX;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                abort_pend_next = 1'b0;
                state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy_o       = (state_reg != ST_IDLE);
    assign done_o       = (state_reg == ST_DONE);
    assign count_o      = count_reg;
    assign iob_avalid_o = avalid_reg;
    assign iob_addr_o   = addr_reg;
    assign iob_wdata_o  = wdata_reg;
    assign iob_wstrb_o  = wstrb_reg;
    assign m_valid_o    = m_valid_reg;
    assign m_data_o     = m_data_reg;
    assign m_last_o     = m_last_reg;
endmodule

// File: tb/tb_iob_ila_dump.sv
// Bench for iob_ila_dump: two instances (1 and 2 words per sample) share an ILA
// register-file model and a stream sink; one instance is active at a time.
module tb_iob_ila_dump;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic cke = 1'b1, arst = 1'b1, start_sig = 1'b0, abort_sig = 1'b0;
    int   cur = 0;

    logic        busy [NI], done [NI], avalid [NI], m_valid [NI], m_last [NI];
    logic [15:0] count [NI];
    logic [3:0]  addr [NI], wstrb [NI];
    logic [31:0] wdata [NI], m_data [NI];

    logic        ready_d = 1'b0, rvalid_d = 1'b0, force_rv = 1'b0, m_ready_d = 1'b0;
    logic [31:0] rdata_d = '0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        iob_ila_dump #(.SIGNAL_W(32 * (gi + 1))) u_dut (
            .clk_i        (clk),
            .cke_i        (cke),
            .arst_i       (arst),
            .start_i      (start_sig && (cur == gi)),
            .abort_i      (abort_sig && (cur == gi)),
            .busy_o       (busy[gi]),
            .done_o       (done[gi]),
            .count_o      (count[gi]),
            .iob_avalid_o (avalid[gi]),
            .iob_addr_o   (addr[gi]),
            .iob_wdata_o  (wdata[gi]),
            .iob_wstrb_o  (wstrb[gi]),
            .iob_ready_i  (ready_d && (cur == gi)),
            .iob_rvalid_i ((rvalid_d || force_rv) && (cur == gi)),
            .iob_rdata_i  (rdata_d),
            .m_valid_o    (m_valid[gi]),
            .m_data_o     (m_data[gi]),
            .m_last_o     (m_last[gi]),
            .m_ready_i    (m_ready_d && (cur == gi))
        );
    end

    int n_checks = 0, n_fail = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ILA register-file model and bus responder
    int          ready_delay = 0, rvalid_delay = 1, req_wait = 0, rv_cnt = -1, req_count = 0;
    int          ila_index = 0, ila_sel = 0;
    bit          req_pend = 0, rd_out = 0, rd_out_data = 0;
    logic [3:0]  req_addr = '0, req_wstrb = '0;
    logic [31:0] req_wdata = '0, rv_data = '0, n_word = '0, seed = '0;
    logic [31:0] idx_log[$], sel_log[$];

    function automatic logic [31:0] sample_word(input int idx, input int sel);
        return {8'(sel), 8'(seed), 16'(idx)};
    endfunction

    always @(negedge clk) begin
        if (ready_d) begin
            ready_d = 1'b0;
            check_eq("avalid_drop", 64'(avalid[cur]), 0);
            if (req_wstrb != 4'h0) begin
                if (req_addr == 4'd1) begin
                    ila_index = int'(req_wdata);
                    idx_log.push_back(req_wdata);
                end else if (req_addr == 4'd2) begin
                    ila_sel = int'(req_wdata);
                    sel_log.push_back(req_wdata);
                end
            end else begin
                rv_data = (req_addr == 4'd0) ? n_word :
                          (req_addr == 4'd3) ? sample_word(ila_index, ila_sel) : 32'hDEAD_BEEF;
                rv_cnt      = rvalid_delay;
                rd_out      = 1'b1;
                rd_out_data = (req_addr == 4'd3);
            end
            req_pend = 1'b0;
        end
        rvalid_d = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                rvalid_d = 1'b1;
                rdata_d  = rv_data;
                rd_out   = 1'b0;
                rv_cnt   = -1;
            end
        end
        if (avalid[cur]) begin
            if (!req_pend) begin
                req_pend  = 1'b1;
                req_wait  = 0;
                req_count++;
                req_addr  = addr[cur];
                req_wdata = wdata[cur];
                req_wstrb = wstrb[cur];
                if (req_wstrb != 4'h0) begin
                    check_eq("wr_strobe", 64'(req_wstrb), 64'hF);
                    check_eq("wr_addr_legal", 64'(req_addr == 4'd1 || req_addr == 4'd2), 1);
                end else begin
                    check_eq("rd_addr_legal", 64'(req_addr == 4'd0 || req_addr == 4'd3), 1);
                end
            end else begin
                check_eq("req_stable", {req_addr, req_wstrb, req_wdata},
                         {addr[cur], wstrb[cur], wdata[cur]});
            end
            if (req_wait >= ready_delay) ready_d = 1'b1;
            else req_wait++;
        end
    end

    // Stream sink with configurable backpressure
    int          m_stall = 0, m_wait = 0, done_seen = 0;
    logic [32:0] m_hold = '0;
    logic [32:0] got_q[$], exp_q[$];
    logic [31:0] exp_idx[$], exp_sel[$];

    always @(negedge clk) begin
        if (m_ready_d) begin
            m_ready_d = 1'b0;
            m_wait    = 0;
        end
        if (m_valid[cur]) begin
            if (m_wait == 0) m_hold = {m_last[cur], m_data[cur]};
            else check_eq("m_stable", 64'({m_last[cur], m_data[cur]}), 64'(m_hold));
            if (m_wait >= m_stall) begin
                m_ready_d = 1'b1;
                got_q.push_back({m_last[cur], m_data[cur]});
            end else begin
                m_wait++;
            end
        end else begin
            m_wait = 0;
        end
        if (done[cur]) done_seen++;
    end

    task automatic begin_dump(input int inst, input int n, input int rd, input int rvd, input int ms);
        int words;
        cur = inst; ready_delay = rd; rvalid_delay = rvd; m_stall = ms;
        words  = inst + 1;
        seed   = $urandom;
        n_word = {16'($urandom), 16'(n)};
        got_q.delete(); exp_q.delete(); idx_log.delete(); sel_log.delete();
        exp_idx.delete(); exp_sel.delete();
        done_seen = 0; req_count = 0;
        for (int i = 0; i < n; i++) begin
            exp_idx.push_back(32'(i));
            for (int w = 0; w < words; w++) begin
                exp_sel.push_back(32'(w));
                exp_q.push_back({(i == n - 1) && (w == words - 1), sample_word(i, w)});
            end
        end
        @(posedge clk); #1 start_sig = 1'b1;
        @(posedge clk); #1 start_sig = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int poke_start);
        int c = 0;
        while (!done[cur] && c < budget) begin
            @(posedge clk); #1;
            c++;
            if (poke_start != 0) start_sig = (c == poke_start);
        end
        start_sig = 1'b0;
        check_eq("done_timeout", 64'(c < budget), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_mvalid(input int budget);
        int c = 0;
        while (!m_valid[cur] && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq("mvalid_timeout", 64'(c < budget), 1);
    endtask

    task automatic check_dump(input string tag, input int n, input int exp_words);
        check_eq({tag, "_words"}, 64'(got_q.size()), 64'(exp_words));
        check_eq({tag, "_model_words"}, 64'(exp_q.size()), 64'(exp_words));
        for (int k = 0; k < exp_q.size(); k++)
            if (k < got_q.size()) check_eq($sformatf("%s_word%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
        check_eq({tag, "_idx_writes"}, 64'(idx_log.size()), 64'(exp_idx.size()));
        for (int k = 0; k < exp_idx.size() && k < idx_log.size(); k++)
            check_eq($sformatf("%s_idx%0d", tag, k), 64'(idx_log[k]), 64'(exp_idx[k]));
        check_eq({tag, "_sel_writes"}, 64'(sel_log.size()), 64'(exp_sel.size()));
        for (int k = 0; k < exp_sel.size() && k < sel_log.size(); k++)
            check_eq($sformatf("%s_sel%0d", tag, k), 64'(sel_log[k]), 64'(exp_sel[k]));
        check_eq({tag, "_done_pulses"}, 64'(done_seen), 1);
        check_eq({tag, "_count"}, 64'(count[cur]), 64'(n));
        check_eq({tag, "_busy_after"}, 64'(busy[cur]), 0);
        $display("dump %s inst=%0d n=%0d words=%0d", tag, cur, n, got_q.size());
    endtask

    task automatic check_zero(input string tag, input int g);
        check_eq({tag, "_busy"}, 64'(busy[g]), 0);
        check_eq({tag, "_done"}, 64'(done[g]), 0);
        check_eq({tag, "_avalid"}, 64'(avalid[g]), 0);
        check_eq({tag, "_mvalid"}, 64'(m_valid[g]), 0);
        check_eq({tag, "_mlast"}, 64'(m_last[g]), 0);
        check_eq({tag, "_addr"}, 64'(addr[g]), 0);
        check_eq({tag, "_wdata"}, 64'(wdata[g]), 0);
        check_eq({tag, "_wstrb"}, 64'(wstrb[g]), 0);
        check_eq({tag, "_mdata"}, 64'(m_data[g]), 0);
        check_eq({tag, "_count"}, 64'(count[g]), 0);
    endtask

    typedef struct {
        string name;
        int    inst, n, rd, rvd, ms, poke, exp_words;
    } row_t;

    row_t        tbl[6];
    logic [28:0] snap_a;
    logic [63:0] snap_b;
    int          req_at_abort;

    initial begin
        tbl[0] = '{"basic",     0, 3, 0, 1, 0, 0, 3};
        tbl[1] = '{"multiword", 1, 2, 0, 1, 0, 0, 4};
        tbl[2] = '{"empty",     0, 0, 0, 1, 0, 0, 0};
        tbl[3] = '{"stall32",   0, 3, 3, 2, 5, 0, 3};
        tbl[4] = '{"stall64",   1, 2, 3, 2, 5, 0, 4};
        tbl[5] = '{"startbusy", 0, 4, 1, 1, 1, 6, 4};

        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) check_zero($sformatf("reset%0d", g), g);
        arst = 1'b0;

        foreach (tbl[r]) begin
            begin_dump(tbl[r].inst, tbl[r].n, tbl[r].rd, tbl[r].rvd, tbl[r].ms);
            wait_done(5000, tbl[r].poke);
            check_dump(tbl[r].name, tbl[r].n, tbl[r].exp_words);
        end

        for (int r = 0; r < 8; r++) begin
            int inst, n;
            inst = int'($urandom_range(0, 1));
            n    = int'($urandom_range(0, 6));
            begin_dump(inst, n, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                       int'($urandom_range(0, 3)));
            wait_done(5000, 0);
            check_dump($sformatf("rand%0d", r), n, n * (inst + 1));
        end

        // Abort while the SAMPLE_DATA read of sample 1 is outstanding
        begin_dump(0, 4, 0, 3, 0);
        begin
            int c = 0;
            while (!(rd_out && rd_out_data && ila_index == 1) && c < 2000) begin
                @(posedge clk); #1;
                c++;
            end
            check_eq("abort_window_timeout", 64'(c < 2000), 1);
        end
        req_at_abort = req_count;
        abort_sig = 1'b1;
        @(posedge clk); #1 abort_sig = 1'b0;
        wait_done(2000, 0);
        check_eq("abort_words", 64'(got_q.size()), 1);
        if (got_q.size() > 0) check_eq("abort_word0", 64'(got_q[0]), 64'(exp_q[0]));
        check_eq("abort_no_new_req", 64'(req_count), 64'(req_at_abort));
        check_eq("abort_rvalid_consumed", 64'(rd_out), 0);
        check_eq("abort_done_pulses", 64'(done_seen), 1);
        check_eq("abort_busy_after", 64'(busy[cur]), 0);
        $display("dump abort inst=%0d words=%0d", cur, got_q.size());

        // Clock enable low while a word waits in OUT: everything freezes
        begin_dump(1, 2, 0, 1, 1000000);
        wait_mvalid(2000);
        @(posedge clk); #1;
        snap_a = {busy[1], done[1], count[1], avalid[1], addr[1], wstrb[1], m_valid[1], m_last[1]};
        snap_b = {wdata[1], m_data[1]};
        cke = 1'b0; abort_sig = 1'b1; start_sig = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("cke_hold_ctrl", 64'({busy[1], done[1], count[1], avalid[1], addr[1], wstrb[1],
                                       m_valid[1], m_last[1]}), 64'(snap_a));
        check_eq("cke_hold_data", {wdata[1], m_data[1]}, snap_b);
        abort_sig = 1'b0; start_sig = 1'b0; cke = 1'b1; m_stall = 0;
        wait_done(5000, 0);
        check_dump("cke", 2, 4);

        // Reset during OUT, a stray rvalid in IDLE, then a full dump
        begin_dump(0, 3, 0, 1, 1000000);
        wait_mvalid(2000);
        @(posedge clk); #1 arst = 1'b1;
        @(posedge clk); #1;
        check_zero("midreset", 0);
        arst = 1'b0;
        req_pend = 1'b0; rd_out = 1'b0; rv_cnt = -1; m_stall = 0;
        force_rv = 1'b1;
        @(posedge clk); #1 force_rv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("late_rvalid_busy", 64'(busy[0]), 0);
        check_eq("late_rvalid_avalid", 64'(avalid[0]), 0);
        check_eq("late_rvalid_count", 64'(count[0]), 0);
        begin_dump(0, 3, 0, 1, 0);
        wait_done(5000, 0);
        check_dump("postreset", 3, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
